// File: rtl/params_pkg.sv
// Shared types and constants for the CPU <-> memory request interface.
package params_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    localparam int unsigned MEM_LATENCY_DEFAULT = 4;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR (x^8 + x^6 + x^5 + x^4 + 1), free-running, reseeded on reset.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [7:0] lfsr_o
);

    logic [7:0] r_lfsr;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    assign lfsr_o = r_lfsr;

endmodule

// File: rtl/mem_responder.sv
// Byte-addressed little-endian memory responder: one request at a time, fixed latency.
// Define MEM_RAND_LATENCY_EN to add 0-3 cycles of LFSR-driven latency per request.
module mem_responder
    import params_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_SIZE    = 4096,
    parameter int unsigned MEM_LATENCY = MEM_LATENCY_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rd_req_valid_i,
    input  logic                  wr_req_valid_i,
    input  logic                  req_is_instr_i,
    input  logic [ADDR_WIDTH-1:0] req_address_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  access_size_t          req_access_size_i,
    output logic                  mem_data_valid_o,
    output logic                  mem_data_is_instr_o,
    output logic [DATA_WIDTH-1:0] mem_data_o,
    output logic                  busy_o
);

    localparam int unsigned AW    = $clog2(MEM_SIZE);
    localparam int unsigned NB    = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = $clog2(MEM_LATENCY + 4) + 1;

    mem_resp_state_t       r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [AW-1:0]         r_addr;
    access_size_t          r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_is_instr;
    logic                  r_is_read;
    logic [7:0]            r_mem [MEM_SIZE];

    logic [AW-1:0]         w_idx [NB];
    logic [DATA_WIDTH-1:0] w_raw;
    logic [NB-1:0]         w_mask;
    logic [CNT_W-1:0]      w_lat;
    logic                  w_req;
    logic                  w_unused_addr;

    function automatic int unsigned size_bytes(access_size_t s);
        case (s)
            BYTE:    return 1;
            HALF:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [NB-1:0] lane_mask(access_size_t s);
        logic [NB-1:0] m;
        for (int unsigned i = 0; i < NB; i++) begin
            m[i] = (i < size_bytes(s));
        end
        return m;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] gather(logic [DATA_WIDTH-1:0] raw,
                                                     access_size_t s);
        logic [DATA_WIDTH-1:0] d;
        logic [NB-1:0]         m;
        m = lane_mask(s);
        for (int unsigned i = 0; i < NB; i++) begin
            d[i*8 +: 8] = m[i] ? raw[i*8 +: 8] : 8'h00;
        end
        return d;
    endfunction

    assign w_req         = rd_req_valid_i | wr_req_valid_i;
    assign w_mask        = lane_mask(r_size);
    assign w_unused_addr = ^req_address_i[ADDR_WIDTH-1:AW];

`ifdef MEM_RAND_LATENCY_EN
    logic [7:0] w_lfsr;
    logic       w_unused_lfsr;

    lfsr8 #(.SEED(8'hA5)) u_lfsr (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .lfsr_o (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[7:2];
    assign w_lat         = CNT_W'(MEM_LATENCY) + CNT_W'(w_lfsr[1:0]);
`else
    assign w_lat = CNT_W'(MEM_LATENCY);
`endif

    // Byte addresses wrap modulo MEM_SIZE by truncation to AW bits.
    always_comb begin
        w_raw = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_idx[i]       = r_addr + AW'(i);
            w_raw[i*8 +: 8] = r_mem[w_idx[i]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_state_next = (w_lat == CNT_W'(1)) ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_W'(1)) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Read wins over a simultaneous write; the write data is simply never used.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt      <= '0;
            r_addr     <= '0;
            r_size     <= BYTE;
            r_wdata    <= '0;
            r_is_instr <= 1'b0;
            r_is_read  <= 1'b0;
        end else if (r_state == IDLE && w_req) begin
            r_cnt      <= w_lat - CNT_W'(1);
            r_addr     <= req_address_i[AW-1:0];
            r_size     <= req_access_size_i;
            r_wdata    <= wr_data_i;
            r_is_instr <= req_is_instr_i;
            r_is_read  <= rd_req_valid_i;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (r_state == RESP && !r_is_read) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (w_mask[i]) r_mem[w_idx[i]] <= r_wdata[i*8 +: 8];
            end
        end
    end

    always_comb begin
        mem_data_valid_o    = 1'b0;
        mem_data_is_instr_o = 1'b0;
        mem_data_o          = '0;
        busy_o              = 1'b0;
        unique case (r_state)
            WAIT: busy_o = 1'b1;
            RESP: begin
                busy_o           = 1'b1;
                mem_data_valid_o = 1'b1;
                if (r_is_read) begin
                    mem_data_is_instr_o = r_is_instr;
                    mem_data_o          = gather(w_raw, r_size);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default build, MEM_LATENCY=4, MEM_SIZE=4096).
module tb_mem_responder;
    import params_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         rd_req_valid_i;
    logic         wr_req_valid_i;
    logic         req_is_instr_i;
    logic [31:0]  req_address_i;
    logic [31:0]  wr_data_i;
    access_size_t req_access_size_i;
    logic         mem_data_valid_o;
    logic         mem_data_is_instr_o;
    logic [31:0]  mem_data_o;
    logic         busy_o;

    int checks = 0;
    int passes = 0;
    int pulse_cnt = 0;

    mem_responder #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .MEM_SIZE    (4096),
        .MEM_LATENCY (4)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .rd_req_valid_i      (rd_req_valid_i),
        .wr_req_valid_i      (wr_req_valid_i),
        .req_is_instr_i      (req_is_instr_i),
        .req_address_i       (req_address_i),
        .wr_data_i           (wr_data_i),
        .req_access_size_i   (req_access_size_i),
        .mem_data_valid_o    (mem_data_valid_o),
        .mem_data_is_instr_o (mem_data_is_instr_o),
        .mem_data_o          (mem_data_o),
        .busy_o              (busy_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) if (mem_data_valid_o) pulse_cnt++;

    // Issue one request (caller is just past a posedge, DUT idle) and wait for its pulse.
    // lat = negedges from the sampling edge to the pulse, -1 if none within budget.
    task automatic do_req(input logic rd, input logic wr, input logic instr,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input access_size_t size,
                          output logic [31:0] rdata, output logic rinstr, output int lat);
        rd_req_valid_i    = rd;
        wr_req_valid_i    = wr;
        req_is_instr_i    = instr;
        req_address_i     = addr;
        wr_data_i         = wdata;
        req_access_size_i = size;
        rdata  = 32'hxxxx_xxxx;
        rinstr = 1'bx;
        lat    = -1;
        @(posedge clk_i);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk_i);
            if (mem_data_valid_o) begin
                lat    = n;
                rdata  = mem_data_o;
                rinstr = mem_data_is_instr_o;
                break;
            end
        end
        @(posedge clk_i);
        #1;
        rd_req_valid_i = 1'b0;
        wr_req_valid_i = 1'b0;
        req_is_instr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i             = 1'b0;
        rd_req_valid_i    = 1'b1;
        wr_req_valid_i    = 1'b0;
        req_is_instr_i    = 1'b1;
        req_address_i     = 32'h0;
        wr_data_i         = 32'h0;
        req_access_size_i = WORD;
        repeat (3) @(negedge clk_i);
        checks++;
        if (mem_data_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", mem_data_valid_o);
        else passes++;
        checks++;
        if (mem_data_is_instr_o !== 1'b0)
            $display("FAIL reset_instr: got %b want 0", mem_data_is_instr_o);
        else passes++;
        checks++;
        if (mem_data_o !== 32'h0) $display("FAIL reset_data: got %h want 0", mem_data_o);
        else passes++;
        checks++;
        if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o);
        else passes++;
        rd_req_valid_i = 1'b0;
        req_is_instr_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] d;
        logic        ins;
        int          lat;
        do_req(1'b0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, WORD, d, ins, lat);
        checks++;
        if (lat !== 4) $display("FAIL wr_ack_latency: got %0d want 4", lat);
        else passes++;
        checks++;
        if (d !== 32'h0 || ins !== 1'b0)
            $display("FAIL wr_ack_data: got %h/%b want 00000000/0", d, ins);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, WORD, d, ins, lat);
        checks++;
        if (lat !== 4) $display("FAIL rd_latency: got %0d want 4", lat);
        else passes++;
        checks++;
        if (d !== 32'hDEADBEEF || ins !== 1'b0)
            $display("FAIL rd_word: got %h/%b want deadbeef/0", d, ins);
        else passes++;
    endtask

    task automatic test_byte_merge();
        logic [31:0] d;
        logic        ins;
        int          lat;
        // Upper lanes of the store data are garbage and must not be written.
        do_req(1'b0, 1'b1, 1'b0, 32'h101, 32'hFFFFFF5A, BYTE, d, ins, lat);
        do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, HALF, d, ins, lat);
        checks++;
        if (d !== 32'h00005AEF) $display("FAIL rd_half: got %h want 00005aef", d);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, WORD, d, ins, lat);
        checks++;
        if (d !== 32'hDEAD5AEF) $display("FAIL rd_word_merged: got %h want dead5aef", d);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h101, 32'h0, HALF, d, ins, lat);
        checks++;
        if (d !== 32'h0000AD5A) $display("FAIL rd_half_misaligned: got %h want 0000ad5a", d);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h103, 32'h0, BYTE, d, ins, lat);
        checks++;
        if (d !== 32'h000000DE) $display("FAIL rd_byte: got %h want 000000de", d);
        else passes++;
    endtask

    task automatic test_fetch_wrap();
        logic [31:0] d;
        logic        ins;
        int          lat;
        do_req(1'b0, 1'b1, 1'b0, 32'hFFE, 32'h00000011, BYTE, d, ins, lat);
        do_req(1'b0, 1'b1, 1'b0, 32'hFFF, 32'h00000022, BYTE, d, ins, lat);
        do_req(1'b0, 1'b1, 1'b0, 32'h000, 32'h00000033, BYTE, d, ins, lat);
        do_req(1'b0, 1'b1, 1'b0, 32'h001, 32'h00000044, BYTE, d, ins, lat);
        do_req(1'b1, 1'b0, 1'b1, 32'hFFE, 32'h0, WORD, d, ins, lat);
        checks++;
        if (d !== 32'h44332211 || ins !== 1'b1)
            $display("FAIL fetch_wrap: got %h/%b want 44332211/1", d, ins);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h00001FFE, 32'h0, WORD, d, ins, lat);
        checks++;
        if (d !== 32'h44332211 || ins !== 1'b0)
            $display("FAIL addr_modulo: got %h/%b want 44332211/0", d, ins);
        else passes++;
    endtask

    task automatic test_rd_wr_conflict();
        logic [31:0] d;
        logic        ins;
        int          lat;
        do_req(1'b0, 1'b1, 1'b0, 32'h200, 32'h01234567, WORD, d, ins, lat);
        do_req(1'b1, 1'b1, 1'b0, 32'h200, 32'hCAFEF00D, WORD, d, ins, lat);
        checks++;
        if (lat !== 4 || d !== 32'h01234567)
            $display("FAIL rdwr_resp: got lat %0d data %h want 4/01234567", lat, d);
        else passes++;
        do_req(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, WORD, d, ins, lat);
        checks++;
        if (d !== 32'h01234567) $display("FAIL rdwr_mem: got %h want 01234567", d);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        ins;
        int          lat;
        int          p0;
        p0 = pulse_cnt;
        do_req(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, WORD, d, ins, lat);
        checks++;
        if (lat !== 4 || d !== 32'hDEAD5AEF)
            $display("FAIL b2b_first: got lat %0d data %h want 4/dead5aef", lat, d);
        else passes++;
        do_req(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, WORD, d, ins, lat);
        checks++;
        if (lat !== 4 || d !== 32'h01234567 || ins !== 1'b1)
            $display("FAIL b2b_second: got lat %0d data %h instr %b want 4/01234567/1",
                     lat, d, ins);
        else passes++;
        repeat (10) @(negedge clk_i);
        checks++;
        if (pulse_cnt - p0 !== 2) $display("FAIL b2b_pulses: got %0d want 2", pulse_cnt - p0);
        else passes++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        logic        ins;
        int          lat;
        int          p0;
        do_req(1'b0, 1'b1, 1'b0, 32'h300, 32'hA5A5A5A5, WORD, d, ins, lat);
        wr_req_valid_i    = 1'b1;
        req_address_i     = 32'h300;
        wr_data_i         = 32'h5555AAAA;
        req_access_size_i = WORD;
        @(posedge clk_i);
        @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy_o);
        else passes++;
        p0 = pulse_cnt;
        #1 rst_i = 1'b0;
        wr_req_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if ({mem_data_valid_o, mem_data_is_instr_o, busy_o, mem_data_o} !== 35'h0)
                $display("FAIL mid_outputs_in_reset: got v%b i%b b%b d%h want all 0",
                         mem_data_valid_o, mem_data_is_instr_o, busy_o, mem_data_o);
            else passes++;
        end
        rst_i = 1'b1;
        repeat (8) @(negedge clk_i);
        checks++;
        if (pulse_cnt !== p0) $display("FAIL mid_no_resp: got %0d pulses want 0", pulse_cnt - p0);
        else passes++;
        @(posedge clk_i);
        #1;
        do_req(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, WORD, d, ins, lat);
        checks++;
        if (d !== 32'hA5A5A5A5) $display("FAIL mid_old_data: got %h want a5a5a5a5", d);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_fetch_wrap();
        test_rd_wr_conflict();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
